mem_reader: RTL and testbench
=============================

Name: mem_reader

Overview:
- Read-side controller for the word-organised JK-flip-flop memory bank. The bank provides per-word select, a rw line and a shared read-data bus.
- Accepts single-word or burst read requests from a client.
- Drives the bank's one-hot select with rw=0 and waits the bank's access latency.
- Captures the word and returns it through a valid/ready output handshake.
- Sits between the memory array and any consumer, as the counterpart to the existing write path.

Parameters:
- WIDTH, 4, bits per memory word.
- DEPTH, 4, number of words; must be a power of two, at least 2.
- ADDR_W, 2, address width; equals log2(DEPTH).
- MEM_LAT, 1, cycles mem_sel must be held before mem_data is valid; range 1..7.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req  input  1  read request; sampled only in IDLE.
- addr  input  ADDR_W  start word address; sampled with req.
- burst  input  1  sampled with req: 1 reads all DEPTH words starting at addr, 0 reads a single word.
- busy  output  1  high from the req-accept edge until the final handshake edge.
- mem_sel  output  DEPTH  one-hot word select to the bank (the bank's add line per word).
- mem_rw  output  1  bank read/write control; held 0 at all times.
- mem_data  input  WIDTH  read data from the bank.
- dout  output  WIDTH  captured word.
- dvalid  output  1  dout valid.
- dready  input  1  consumer accepts dout.
- dlast  output  1  high together with dvalid on the final word of a transfer.

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE; busy=0, mem_sel=0, mem_rw=0, dout=0, dvalid=0, dlast=0; word and latency counters cleared.
  - Reset has priority over everything and aborts any transfer, mid-ISSUE or mid-PRESENT, with no further handshake.
- States: IDLE, ISSUE, PRESENT.
- IDLE:
  - req=1 at edge t0: latch ptr=addr, remaining=(burst ? DEPTH : 1); busy=1; go to ISSUE.
  - req=0: stay.
- ISSUE:
  - mem_sel = one-hot(ptr), registered, so it is asserted in the cycle immediately after the entering edge.
  - Latency counter counts MEM_LAT edges. At the MEM_LAT-th edge: dout<=mem_data, dvalid<=1, dlast<=(remaining==1), mem_sel<=0; go to PRESENT.
  - Latency: dvalid is high after edge t0+MEM_LAT.
- PRESENT:
  - dout, dlast and dvalid are held stable while dready=0; no timeout.
  - Edge with dready=1 is the handshake:
    - dvalid<=0, dlast<=0 on that edge.
    - If remaining>1: remaining-=1, ptr<=(ptr+1) mod DEPTH (wraps DEPTH-1 to 0); go to ISSUE, with mem_sel asserted in the following cycle.
    - Else: busy<=0; go to IDLE.
  - dready=1 already on the edge dvalid rises is not a handshake. The transfer happens on the first edge where dvalid was already 1 and dready=1.
- Request rules:
  - req/addr/burst are ignored while busy=1.
  - req high at the same edge the final handshake completes is ignored. A new request is accepted at the next edge at the earliest.
- Output rules:
  - mem_sel is never multi-hot and is 0 outside ISSUE.
  - dvalid is never high in ISSUE or IDLE.
- Burst throughput: one word per MEM_LAT+1 cycles when dready is held high. Exactly DEPTH handshakes occur; dlast is high only on the last.
- mem_data is sampled only on the capture edge; changes at any other time have no effect.
- Widths: ptr is ADDR_W bits, wrapping naturally. remaining is ADDR_W+1 bits, so the value DEPTH is representable.

Test Plan:
Bank model preloaded with word0=0101, word1=0111, word2=0110, word3=1110; MEM_LAT=1.
- Reset: hold reset=0 for 2 edges with req=1 -> busy=0, mem_sel=0000, dvalid=0, dout=0000 throughout.
- Single read: req=1, addr=2, burst=0 at edge t0, dready=1 -> mem_sel=0100 during cycle t0..t0+1; dout=0110, dvalid=1, dlast=1 after t0+1; handshake at t0+2; busy=0 after t0+2.
- Backpressure: single read at addr=3 with dready=0 for 5 cycles, then 1 -> dout=1110 and dvalid=1 held stable all 5 cycles; exactly one handshake; mem_sel=0000 during the wait.
- Wrapping burst: req=1, addr=3, burst=1, dready=1 -> handshakes deliver 1110, 0101, 0111, 0110 in order, one every 2 cycles; dlast only on 0110; busy drops after the 4th handshake.
- Ignored request: req=1 with addr=0 pulsed during an active burst, and again at the final-handshake edge -> no extra reads; the next req is accepted one edge later.
- Reset mid-operation: reset=0 while in PRESENT with dvalid=1 -> next edge all outputs 0 and state IDLE; a subsequent single read of addr=1 returns 0111 correctly.

Source files
------------

// File: rtl/mem_reader.sv
// Read-side controller for a word-organised memory bank: issues a one-hot word select,
// waits the bank latency, captures the word and hands it out over valid/ready.
module mem_reader #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              burst,
    output logic              busy,
    output logic [DEPTH-1:0]  mem_sel,
    output logic              mem_rw,
    input  logic [WIDTH-1:0]  mem_data,
    output logic [WIDTH-1:0]  dout,
    output logic              dvalid,
    input  logic              dready,
    output logic              dlast
);

    typedef enum logic [1:0] {StIdle, StIssue, StPresent} state_e;

    localparam logic [ADDR_W:0]  BurstLen = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  One      = (ADDR_W + 1)'(1);
    localparam logic [2:0]       LatLast  = 3'(MEM_LAT - 1);
    localparam logic [DEPTH-1:0] SelOne   = DEPTH'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W:0]   remaining_q;
    logic [2:0]        lat_cnt_q;
    logic              busy_q;
    logic [DEPTH-1:0]  mem_sel_q;
    logic [WIDTH-1:0]  dout_q;
    logic              dvalid_q;
    logic              dlast_q;

    // ptr is ADDR_W wide, so the increment wraps DEPTH-1 back to 0.
    assign ptr_next = ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            remaining_q <= '0;
            lat_cnt_q   <= '0;
            busy_q      <= 1'b0;
            mem_sel_q   <= '0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            dlast_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        ptr_q       <= addr;
                        remaining_q <= burst ? BurstLen : One;
                        busy_q      <= 1'b1;
                        mem_sel_q   <= SelOne << addr;
                        lat_cnt_q   <= '0;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (lat_cnt_q == LatLast) begin
                        dout_q    <= mem_data;
                        dvalid_q  <= 1'b1;
                        dlast_q   <= (remaining_q == One);
                        mem_sel_q <= '0;
                        state_q   <= StPresent;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                StPresent: begin
                    // dvalid is already high on every edge seen here, so dready alone
                    // marks the handshake.
                    if (dready) begin
                        dvalid_q <= 1'b0;
                        dlast_q  <= 1'b0;
                        if (remaining_q > One) begin
                            remaining_q <= remaining_q - One;
                            ptr_q       <= ptr_next;
                            mem_sel_q   <= SelOne << ptr_next;
                            lat_cnt_q   <= '0;
                            state_q     <= StIssue;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = busy_q;
    assign mem_sel = mem_sel_q;
    assign mem_rw  = 1'b0;
    assign dout    = dout_q;
    assign dvalid  = dvalid_q;
    assign dlast   = dlast_q;

endmodule

// File: tb/tb_mem_reader.sv
// Randomised bench for mem_reader: a transaction-level model predicts every output cycle by cycle.
module tb_mem_reader;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned MEM_LAT = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              burst = 1'b0;
    logic              busy;
    logic [DEPTH-1:0]  mem_sel;
    logic              mem_rw;
    logic [WIDTH-1:0]  mem_data;
    logic [WIDTH-1:0]  dout;
    logic              dvalid;
    logic              dready = 1'b1;
    logic              dlast;

    mem_reader #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .addr    (addr),
        .burst   (burst),
        .busy    (busy),
        .mem_sel (mem_sel),
        .mem_rw  (mem_rw),
        .mem_data(mem_data),
        .dout    (dout),
        .dvalid  (dvalid),
        .dready  (dready),
        .dlast   (dlast)
    );

    always #5 clk = ~clk;

    // Bank model: selected word when exactly one select is high, junk otherwise.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] junk = '0;
    always_comb begin
        mem_data = junk;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_sel == DEPTH'(1) << i) mem_data = mem[i];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DEPTH-1:0] onehot(input int unsigned a);
        logic [DEPTH-1:0] v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Reference model: queue of word addresses still to be delivered for the current transfer.
    int unsigned      addr_q[$];
    bit               m_busy = 1'b0;
    bit               m_valid = 1'b0;
    int               m_wait = 0;
    logic [WIDTH-1:0] m_dout = '0;
    int               m_accepts = 0;
    int               dut_hs = 0;
    bit               mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", busy, m_busy);
            check("dvalid", dvalid, m_valid);
            check("mem_sel", mem_sel, (m_busy && !m_valid) ? onehot(addr_q[0]) : '0);
            check("dout", dout, m_dout);
            check("dlast", dlast, m_valid && addr_q.size() == 1);
            check("mem_rw", mem_rw, 0);
            if (dvalid && dready) dut_hs++;

            // Predict the effect of the coming rising edge.
            if (!reset) begin
                m_busy = 1'b0;
                m_valid = 1'b0;
                m_dout = '0;
                addr_q.delete();
            end else if (!m_busy) begin
                if (req) begin
                    for (int i = 0; i < (burst ? DEPTH : 1); i++) addr_q.push_back((addr + i) % DEPTH);
                    m_busy = 1'b1;
                    m_wait = MEM_LAT;
                    m_accepts++;
                end
            end else if (!m_valid) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1'b1;
                    m_dout = mem[addr_q[0]];
                end
            end else if (dready) begin
                void'(addr_q.pop_front());
                m_valid = 1'b0;
                if (addr_q.size() == 0) m_busy = 1'b0;
                else m_wait = MEM_LAT;
            end
        end
        junk = WIDTH'($urandom);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        req = 1'b0;
        dready = 1'b1;
        reset = 1'b1;
        while (m_busy && n < 200) begin
            tick();
            n++;
        end
        check("idle", busy, 0);
    endtask

    task automatic do_read(input int unsigned a, input bit b);
        req = 1'b1;
        addr = ADDR_W'(a);
        burst = b;
        tick();
        req = 1'b0;
    endtask

    int hs0;
    int n;

    initial begin
        mem[0] = 4'b0101;
        mem[1] = 4'b0111;
        mem[2] = 4'b0110;
        mem[3] = 4'b1110;

        // Reset held with req high.
        reset = 1'b0;
        req = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        req = 1'b0;
        reset = 1'b1;
        tick();

        // Single read.
        hs0 = dut_hs;
        do_read(2, 0);
        wait_idle();
        check("single_hs", dut_hs - hs0, 1);

        // Backpressure.
        hs0 = dut_hs;
        dready = 1'b0;
        do_read(3, 0);
        repeat (6) tick();
        check("bp_no_hs", dut_hs - hs0, 0);
        check("bp_dout", dout, 4'b1110);
        dready = 1'b1;
        wait_idle();
        check("bp_hs", dut_hs - hs0, 1);

        // Wrapping burst.
        hs0 = dut_hs;
        do_read(3, 1);
        wait_idle();
        check("burst_hs", dut_hs - hs0, 4);

        // Requests during a burst and at its final handshake are ignored.
        hs0 = dut_hs;
        do_read(3, 1);
        tick();
        req = 1'b1;
        addr = '0;
        burst = 1'b0;
        tick();
        req = 1'b0;
        tick();
        n = m_accepts;
        req = 1'b1;
        for (int i = 0; i < 40 && m_accepts == n; i++) tick();
        req = 1'b0;
        wait_idle();
        check("ignore_hs", dut_hs - hs0, 5);

        // Reset while presenting.
        dready = 1'b0;
        do_read(0, 0);
        for (int i = 0; i < 20 && !dvalid; i++) tick();
        check("rst_dvalid", dvalid, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rst_busy", busy, 0);
        hs0 = dut_hs;
        do_read(1, 0);
        wait_idle();
        check("rst_hs", dut_hs - hs0, 1);

        // Randomised transfers with random contents, backpressure, stray requests and resets.
        for (int t = 0; t < 60; t++) begin
            wait_idle();
            for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
            do_read($urandom_range(0, DEPTH - 1), bit'($urandom_range(0, 1)));
            for (int c = 0; c < 60 && m_busy; c++) begin
                dready = ($urandom_range(0, 2) != 0);
                req = ($urandom_range(0, 3) == 0);
                addr = ADDR_W'($urandom);
                burst = bit'($urandom_range(0, 1));
                reset = ($urandom_range(0, 49) != 0);
                tick();
            end
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
